// File: rtl/scope_trace_buffer.sv
// Multi-channel scope capture buffer: quantises samples to screen rows and stores them in a
// circular column buffer, either rolling freely or as an armed, edge-triggered single sweep.
module scope_trace_buffer #(
  parameter int NCH     = 2,
  parameter int DW      = 12,
  parameter int RW      = 6,
  parameter int DEPTH   = 32,
  parameter int PRETRIG = 8,
  localparam int TW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [NCH*DW-1:0]   sample_data,
  input  logic                mode,
  input  logic                arm,
  input  logic [TW-1:0]       trig_ch,
  input  logic [DW-1:0]       trig_level,
  input  logic [AW-1:0]       rd_col,
  output logic [NCH*RW-1:0]   rd_row,
  output logic                busy,
  output logic                triggered,
  output logic                done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ROLL      = 3'd1;
  localparam logic [2:0] PREFILL   = 3'd2;
  localparam logic [2:0] WAIT_TRIG = 3'd3;
  localparam logic [2:0] POST      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [2:0]    ARM_ST    = (PRETRIG == 0) ? WAIT_TRIG : PREFILL;
  localparam logic [2:0]    HIT_ST    = (DEPTH - PRETRIG - 1 == 0) ? DONE : POST;
  localparam logic [AW-1:0] PRE_A     = AW'(PRETRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 2);
  localparam logic [AW-1:0] ONE_A     = AW'(1);

  logic [2:0]        state_r, next_state_s;
  logic [AW-1:0]     wr_ptr_r, trig_ptr_r, pre_cnt_r, post_cnt_r;
  logic [DW-1:0]     prev_r, cur_s;
  logic              prev_valid_r;
  logic [NCH*RW-1:0] rows_s, rd_row_r;
  logic [NCH*RW-1:0] mem_r [DEPTH];
  logic              busy_r, triggered_r, done_r;
  logic              capture_s, restart_s, accept_s, hit_s;
  logic [AW-1:0]     start_s, rd_addr_s;

  // Trigger-channel selection and row quantisation of every channel
  always_comb begin
    cur_s  = '0;
    rows_s = '0;
    for (int c = 0; c < NCH; c++) begin
      rows_s[c*RW +: RW] = sample_data[c*DW + DW - RW +: RW];
      if (trig_ch == TW'(c)) begin
        cur_s = sample_data[c*DW +: DW];
      end else begin
        cur_s = cur_s;
      end
    end
  end

  // Arm wins over a same-cycle sample, which is then dropped
  always_comb begin
    capture_s = (state_r == PREFILL) || (state_r == WAIT_TRIG) || (state_r == POST);
    restart_s = mode && arm && (capture_s || (state_r == IDLE) || (state_r == DONE));
    accept_s  = !reset && sample_valid && ((state_r == ROLL) || capture_s) && !restart_s;
    hit_s     = accept_s && mode && (state_r == WAIT_TRIG) && prev_valid_r &&
                (prev_r < trig_level) && (cur_s >= trig_level);
    start_s   = (state_r == DONE) ? (trig_ptr_r - PRE_A) : wr_ptr_r;
    rd_addr_s = start_s + rd_col;
  end

  // Next-state decode; leaving triggered mode always wins, then arm
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!mode)     next_state_s = ROLL;
        else if (arm)  next_state_s = ARM_ST;
        else           next_state_s = IDLE;
      end
      ROLL: begin
        if (mode) next_state_s = IDLE;
        else      next_state_s = ROLL;
      end
      PREFILL, WAIT_TRIG, POST: begin
        if (!mode)          next_state_s = ROLL;
        else if (restart_s) next_state_s = ARM_ST;
        else if (state_r == PREFILL && accept_s && pre_cnt_r == PRE_LAST)
          next_state_s = WAIT_TRIG;
        else if (hit_s)     next_state_s = HIT_ST;
        else if (state_r == POST && accept_s && post_cnt_r == POST_LAST)
          next_state_s = DONE;
        else                next_state_s = state_r;
      end
      DONE: begin
        if (!mode)     next_state_s = ROLL;
        else if (arm)  next_state_s = ARM_ST;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, pointers, counters, trigger history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      trig_ptr_r   <= '0;
      pre_cnt_r    <= '0;
      post_cnt_r   <= '0;
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
      rd_row_r     <= '0;
      busy_r       <= 1'b0;
      triggered_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      rd_row_r <= mem_r[rd_addr_s];
      if (accept_s) wr_ptr_r <= wr_ptr_r + ONE_A;
      if (hit_s) trig_ptr_r <= wr_ptr_r;
      if (restart_s) begin
        pre_cnt_r    <= '0;
        post_cnt_r   <= '0;
        prev_valid_r <= 1'b0;
      end else begin
        if (accept_s && state_r == PREFILL) pre_cnt_r <= pre_cnt_r + ONE_A;
        if (hit_s) post_cnt_r <= '0;
        else if (accept_s && state_r == POST) post_cnt_r <= post_cnt_r + ONE_A;
        if (accept_s) begin
          prev_r       <= cur_s;
          prev_valid_r <= 1'b1;
        end
      end
      busy_r      <= (next_state_s == PREFILL) || (next_state_s == WAIT_TRIG) ||
                     (next_state_s == POST);
      triggered_r <= (next_state_s == POST) || (next_state_s == DONE);
      done_r      <= (next_state_s == DONE);
    end
  end

  // Column storage is deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (accept_s) mem_r[wr_ptr_r] <= rows_s;
  end

  assign rd_row    = rd_row_r;
  assign busy      = busy_r;
  assign triggered = triggered_r;
  assign done      = done_r;

endmodule

// File: tb/tb_scope_trace_buffer.sv
// Directed bench for scope_trace_buffer: behavioural capture model checked every cycle,
// plus hand-computed row and flag expectations for roll, sweep, masking and restart.
module tb_scope_trace_buffer;
  localparam int NCH = 2, DW = 12, RW = 6, DEPTH = 32, PRETRIG = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_valid = 1'b0;
  logic [NCH*DW-1:0] sample_data = '0;
  logic              mode = 1'b1;
  logic              arm = 1'b0;
  logic [0:0]        trig_ch = 1'b0;
  logic [DW-1:0]     trig_level = 12'd2048;
  logic [4:0]        rd_col = 5'd0;
  logic [NCH*RW-1:0] rd_row;
  logic              busy, triggered, done;

  int n_cmp = 0, n_bad = 0;

  scope_trace_buffer #(.NCH(NCH), .DW(DW), .RW(RW), .DEPTH(DEPTH), .PRETRIG(PRETRIG)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .mode(mode), .arm(arm), .trig_ch(trig_ch), .trig_level(trig_level), .rd_col(rd_col),
    .rd_row(rd_row), .busy(busy), .triggered(triggered), .done(done));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int S_IDLE = 0, S_ROLL = 1, S_PRE = 2, S_WT = 3, S_POST = 4, S_DONE = 5;
  int                st = S_IDLE, wp = 0, tp = 0, pre_n = 0, post_n = 0, prev = 0;
  bit                pv = 1'b0, trg = 1'b0, started = 1'b0;
  logic [NCH*RW-1:0] mm [DEPTH];
  bit                seen [DEPTH];
  logic [NCH*RW-1:0] m_rd = '0;
  bit                m_rd_known = 1'b0, m_busy = 1'b0, m_trg = 1'b0, m_done = 1'b0;

  task start_sweep();
    pre_n = 0; post_n = 0; trg = 1'b0; pv = 1'b0;
    st = (PRETRIG == 0) ? S_WT : S_PRE;
  endtask

  always @(posedge clk) begin
    int idx, cur;
    bit cap, rarm, acc, hit;
    logic [NCH*RW-1:0] rows;
    if (reset) begin
      st = S_IDLE; wp = 0; tp = 0; pre_n = 0; post_n = 0; pv = 1'b0; trg = 1'b0;
      m_rd = '0; m_rd_known = 1'b1; started = 1'b1;
    end else begin
      idx = (((st == S_DONE) ? tp - PRETRIG : wp) + int'(rd_col) + 2*DEPTH) % DEPTH;
      m_rd = mm[idx]; m_rd_known = seen[idx];
      cap  = (st == S_PRE) || (st == S_WT) || (st == S_POST);
      rarm = mode && arm && (cap || st == S_IDLE || st == S_DONE);
      acc  = sample_valid && (st == S_ROLL || cap) && !rarm;
      cur  = int'((sample_data >> (int'(trig_ch) * DW)) & ((1 << DW) - 1));
      hit  = acc && mode && st == S_WT && pv && prev < int'(trig_level) && cur >= int'(trig_level);
      if (hit) tp = wp;
      if (acc) begin
        for (int c = 0; c < NCH; c++)
          rows[c*RW +: RW] = RW'(int'((sample_data >> (c*DW)) & ((1 << DW) - 1)) / (1 << (DW - RW)));
        mm[wp] = rows; seen[wp] = 1'b1; wp = (wp + 1) % DEPTH;
        prev = cur; pv = 1'b1;
      end
      case (st)
        S_IDLE: if (!mode) st = S_ROLL; else if (arm) start_sweep();
        S_ROLL: if (mode) st = S_IDLE;
        S_DONE: if (!mode) begin st = S_ROLL; trg = 1'b0; end else if (arm) start_sweep();
        default: begin
          if (!mode) begin st = S_ROLL; trg = 1'b0; end
          else if (arm) start_sweep();
          else if (st == S_PRE && acc) begin
            pre_n++;
            if (pre_n == PRETRIG) st = S_WT;
          end else if (hit) begin
            trg = 1'b1; post_n = 0;
            st = (DEPTH - PRETRIG - 1 == 0) ? S_DONE : S_POST;
          end else if (st == S_POST && acc) begin
            post_n++;
            if (post_n == DEPTH - PRETRIG - 1) st = S_DONE;
          end
        end
      endcase
    end
    m_busy = (st == S_PRE) || (st == S_WT) || (st == S_POST);
    m_trg  = trg;
    m_done = (st == S_DONE);
  end

  // Per-cycle comparison against the model, away from the clock edge
  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if ({busy, triggered, done} !== {m_busy, m_trg, m_done}) begin
        n_bad++;
        $display("FAIL flags t=%0t actual busy/trig/done=%b%b%b required=%b%b%b",
                 $time, busy, triggered, done, m_busy, m_trg, m_done);
      end
      if (m_rd_known) begin
        n_cmp++;
        if (rd_row !== m_rd) begin
          n_bad++;
          $display("FAIL rd_row t=%0t actual=%h required=%h", $time, rd_row, m_rd);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] c0);
    sample_valid = 1'b1;
    sample_data  = {~c0, c0};
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic read_col(input int col, output int row0);
    rd_col = 5'(col);
    tick();
    row0 = int'(rd_row[RW-1:0]);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  initial begin
    int r;
    repeat (3) tick();
    check("reset_rd_row", int'(rd_row), 0);
    check("reset_flags", int'({busy, triggered, done}), 0);
    reset = 1'b0;
    repeat (4) tick();
    check("idle_flags", int'({busy, triggered, done}), 0);

    // roll mode
    mode = 1'b0; tick();
    for (int k = 0; k < 40; k++) send(12'(k * 64));
    read_col(0, r);  check("roll_col0", r, 8);
    read_col(31, r); check("roll_col31", r, 39);
    check("roll_busy_done", int'({busy, done}), 0);

    // idle accepts no samples
    mode = 1'b1; tick();
    repeat (3) send(12'd4095);
    read_col(0, r);  check("idle_nowrite_col0", r, 8);

    // triggered sweep
    pulse_arm();
    repeat (20) send(12'd0);
    check("sweep_pre_trig", int'(triggered), 0);
    send(12'd2048);
    check("sweep_trig", int'(triggered), 1);
    repeat (22) send(12'd4095);
    check("sweep_not_done", int'(done), 0);
    send(12'd4095);
    check("sweep_done", int'(done), 1);
    read_col(7, r); check("sweep_col7", r, 0);
    read_col(8, r); check("sweep_col8", r, 32);
    for (int c = 9; c < 32; c++) begin
      read_col(c, r); check("sweep_post_col", r, 63);
    end
    repeat (5) send(12'd100);
    read_col(8, r);  check("frozen_col8", r, 32);
    read_col(31, r); check("frozen_col31", r, 63);

    // pre-trigger masking
    pulse_arm();
    check("rearm_flags", int'({busy, triggered, done}), 3'b100);
    send(12'd0); send(12'd0); send(12'd3000);
    check("mask_s3", int'(triggered), 0);
    repeat (8) send(12'd0);
    check("mask_s11", int'(triggered), 0);
    send(12'd3000);
    check("mask_s12", int'(triggered), 1);
    send(12'd1000); send(12'd1000);

    // arm during POST, with a same-cycle sample that must be dropped
    arm = 1'b1; sample_valid = 1'b1; sample_data = {12'd0, 12'd4095};
    tick();
    arm = 1'b0; sample_valid = 1'b0;
    check("restart_trig", int'(triggered), 0);
    check("restart_busy", int'(busy), 1);
    read_col(31, r); check("restart_discard", r, 15);

    // no false trigger on a level already above threshold
    repeat (40) send(12'd3000);
    check("nofalse_trig", int'(triggered), 0);
    check("nofalse_busy", int'(busy), 1);

    // reset mid-capture
    reset = 1'b1; tick(); reset = 1'b0;
    check("midreset_flags", int'({busy, triggered, done}), 0);
    tick();

    // leaving triggered mode mid-capture
    pulse_arm();
    repeat (3) send(12'd500);
    mode = 1'b0; tick();
    check("exit_mode_flags", int'({busy, triggered, done}), 0);
    repeat (4) send(12'd700);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
